// File: rtl/sq_commit_ctrl.sv
// Store-queue commit/drain controller: counts retired stores, writes the oldest one
// to data memory through an IDLE -> REQ -> DEL handshake and de-allocates the queue head.
module sq_commit_ctrl #(
    parameter int unsigned TO_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        commit,
    input  logic        sq_empty,
    input  logic        head_valid_entry,
    input  logic        head_valid_data,
    input  logic [7:0]  head_addr,
    input  logic [31:0] head_data,
    input  logic        mem_ack,
    output logic [5:0]  head_idx,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        del,
    output logic [6:0]  pend_cnt,
    output logic        stall,
    output logic        err_nodata,
    output logic        err_timeout,
    output logic        err_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DEL  = 2'd2
    } state_t;

    localparam logic [6:0] PEND_MAX   = 7'd64;
    localparam logic [7:0] TO_LIMIT_W = 8'(TO_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_head_idx;
    logic [6:0]  r_pend_cnt;
    logic [6:0]  w_pend_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_err_nodata;
    logic        r_err_timeout;
    logic        r_err_ovf;

    logic        w_head_ready;
    logic        w_start;
    logic        w_nodata;
    logic        w_in_req;
    logic        w_in_del;
    logic        w_full;
    logic        w_commit_drop;
    logic        w_commit_acc;
    logic        w_wait_hit;

    assign w_in_req      = (r_state == REQ);
    assign w_in_del      = (r_state == DEL);
    assign w_full        = (r_pend_cnt == PEND_MAX);
    assign w_head_ready  = (r_pend_cnt != 7'd0) && !sq_empty && head_valid_entry;

    // A full counter can still take a commit in DEL because the drain frees a slot that cycle.
    assign w_commit_drop = commit && w_full && !w_in_del;
    assign w_commit_acc  = commit && !w_commit_drop;

    // TO_LIMIT is at least 1, so TO_LIMIT_W - 1 never underflows.
    assign w_wait_hit    = w_in_req && !mem_ack && (r_wait_cnt >= (TO_LIMIT_W - 8'd1));

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_nodata    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_head_ready) begin
                    if (head_valid_data) begin
                        w_state_nxt = REQ;
                        w_start     = 1'b1;
                    end else begin
                        w_nodata = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_state_nxt = DEL;
                end
            end
            DEL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend_cnt;
        case ({w_commit_acc, w_in_del})
            2'b10:   w_pend_nxt = r_pend_cnt + 7'd1;
            2'b01:   w_pend_nxt = r_pend_cnt - 7'd1;
            default: w_pend_nxt = r_pend_cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_head_idx <= 6'd0;
            r_pend_cnt <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_cnt <= w_pend_nxt;
            if (w_in_del) begin
                r_head_idx <= r_head_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wait_cnt <= 8'd0;
        end else if (w_start) begin
            r_wait_cnt <= 8'd0;
        end else if (w_in_req && !mem_ack && (r_wait_cnt != TO_LIMIT_W)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Write address/data are latched once on entry to REQ and held for the whole request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_start) begin
            r_mem_addr  <= head_addr;
            r_mem_wdata <= head_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_nodata  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            if (w_nodata) begin
                r_err_nodata <= 1'b1;
            end
            if (w_wait_hit) begin
                r_err_timeout <= 1'b1;
            end
            if (w_commit_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Decoded straight from state so an asynchronous reset drops the request at once.
    assign mem_req     = w_in_req;
    assign del         = w_in_del;
    assign stall       = w_full;
    assign head_idx    = r_head_idx;
    assign pend_cnt    = r_pend_cnt;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_nodata  = r_err_nodata;
    assign err_timeout = r_err_timeout;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_sq_commit_ctrl.sv
// Self-checking bench for sq_commit_ctrl: a store-queue model feeds the head entry and a
// scoreboard queue of committed stores is compared against each memory write request.
module tb_sq_commit_ctrl;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } st_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        commit = 1'b0;
    logic        sq_empty = 1'b1;
    logic        head_valid_entry = 1'b0;
    logic        head_valid_data = 1'b0;
    logic [7:0]  head_addr = 8'd0;
    logic [31:0] head_data = 32'd0;
    logic        mem_ack = 1'b0;
    logic [5:0]  head_idx;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        del;
    logic [6:0]  pend_cnt;
    logic        stall;
    logic        err_nodata;
    logic        err_timeout;
    logic        err_ovf;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  sq_addr [64];
    logic [31:0] sq_data [64];
    logic [5:0]  m_head = 6'd0;
    logic [5:0]  m_tail = 6'd0;
    int          m_pend = 0;
    int          del_seen = 0;
    logic        ack_en = 1'b0;
    logic        vd_low = 1'b0;
    st_t         cur = '0;
    st_t         sb_q [$];

    sq_commit_ctrl #(.TO_LIMIT(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .commit           (commit),
        .sq_empty         (sq_empty),
        .head_valid_entry (head_valid_entry),
        .head_valid_data  (head_valid_data),
        .head_addr        (head_addr),
        .head_data        (head_data),
        .mem_ack          (mem_ack),
        .head_idx         (head_idx),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .del              (del),
        .pend_cnt         (pend_cnt),
        .stall            (stall),
        .err_nodata       (err_nodata),
        .err_timeout      (err_timeout),
        .err_ovf          (err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs from the queue model, clock, then update model and scoreboard.
    task automatic step(input logic c, input logic [7:0] a, input logic [31:0] d);
        logic was_del;
        logic prev_req;
        logic acc;
        st_t  e;
        commit           = c;
        sq_empty         = (m_pend == 0);
        head_valid_entry = (m_pend != 0);
        head_valid_data  = !vd_low;
        head_addr        = sq_addr[m_head];
        head_data        = sq_data[m_head];
        mem_ack          = ack_en;
        was_del          = del;
        prev_req         = mem_req;
        acc              = c && ((m_pend != 64) || was_del);
        @(posedge clk);
        #1;
        commit = 1'b0;
        if (acc) begin
            sq_addr[m_tail] = a;
            sq_data[m_tail] = d;
            m_tail          = m_tail + 6'd1;
            e.a             = a;
            e.d             = d;
            sb_q.push_back(e);
            m_pend++;
        end
        if (was_del) begin
            m_head = m_head + 6'd1;
            m_pend--;
            del_seen++;
            n_cmp++;
            if (head_idx !== m_head) begin
                n_err++;
                $display("FAIL sb_head_idx: got %0d want %0d", head_idx, m_head);
            end
        end
        n_cmp++;
        if (pend_cnt !== 7'(m_pend)) begin
            n_err++;
            $display("FAIL sb_pend_cnt: got %0d want %0d", pend_cnt, m_pend);
        end
        n_cmp++;
        if (stall !== (m_pend == 64)) begin
            n_err++;
            $display("FAIL sb_stall: got %b want %b", stall, (m_pend == 64));
        end
        if (!prev_req && mem_req) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_req: mem_req rose with no committed store pending");
            end else begin
                cur = sb_q.pop_front();
                if ((mem_addr !== cur.a) || (mem_wdata !== cur.d)) begin
                    n_err++;
                    $display("FAIL sb_write: got %h/%h want %h/%h", mem_addr, mem_wdata, cur.a, cur.d);
                end
            end
        end else if (prev_req && mem_req) begin
            n_cmp++;
            if ((mem_addr !== cur.a) || (mem_wdata !== cur.d)) begin
                n_err++;
                $display("FAIL sb_stable: got %h/%h want %h/%h", mem_addr, mem_wdata, cur.a, cur.d);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_req, del, stall, err_nodata, err_timeout, err_ovf} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {mem_req, del, stall, err_nodata, err_timeout, err_ovf});
        end
        n_cmp++;
        if ({head_idx, pend_cnt, mem_addr, mem_wdata} !== 53'd0) begin
            n_err++;
            $display("FAIL reset_regs: got idx %0d pend %0d addr %h data %h want all 0",
                     head_idx, pend_cnt, mem_addr, mem_wdata);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        ack_en = 1'b1;
        step(1'b1, 8'h12, 32'hDEADBEEF);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_req_n1: got %b want 0", mem_req);
        end
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((mem_req !== 1'b1) || (mem_addr !== 8'h12) || (mem_wdata !== 32'hDEADBEEF)) begin
            n_err++;
            $display("FAIL single_req_n2: got %b %h/%h want 1 12/deadbeef", mem_req, mem_addr, mem_wdata);
        end
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if (del !== 1'b1) begin
            n_err++;
            $display("FAIL single_del_n3: got %b want 1", del);
        end
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((del !== 1'b0) || (head_idx !== 6'd1) || (pend_cnt !== 7'd0)) begin
            n_err++;
            $display("FAIL single_done: got del %b idx %0d pend %0d want 0 1 0", del, head_idx, pend_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_del;
        ack_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(k < 3, 8'(8'h20 + k), 32'(32'hC0DE_0000 + k));
            exp_del = ((k + 1) == 3) || ((k + 1) == 6) || ((k + 1) == 9);
            n_cmp++;
            if (del !== exp_del) begin
                n_err++;
                $display("FAIL b2b_del_n%0d: got %b want %b", k + 1, del, exp_del);
            end
        end
        n_cmp++;
        if ((head_idx !== 6'd4) || (pend_cnt !== 7'd0)) begin
            n_err++;
            $display("FAIL b2b_done: got idx %0d pend %0d want 4 0", head_idx, pend_cnt);
        end
    endtask

    task automatic test_nodata();
        int start_dels;
        ack_en = 1'b1;
        vd_low = 1'b1;
        step(1'b1, 8'h55, 32'h5555_AAAA);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 32'h0);
            n_cmp++;
            if (mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL nodata_req: got %b want 0", mem_req);
            end
        end
        n_cmp++;
        if (err_nodata !== 1'b1) begin
            n_err++;
            $display("FAIL nodata_flag: got %b want 1", err_nodata);
        end
        vd_low     = 1'b0;
        start_dels = del_seen;
        for (int k = 0; k < 8 && del_seen == start_dels; k++) begin
            step(1'b0, 8'h00, 32'h0);
        end
        n_cmp++;
        if ((del_seen != start_dels + 1) || (head_idx !== 6'd5) || (err_nodata !== 1'b1)) begin
            n_err++;
            $display("FAIL nodata_drain: got dels %0d idx %0d flag %b want 1 5 1",
                     del_seen - start_dels, head_idx, err_nodata);
        end
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pre: got %b want 0", err_timeout);
        end
        step(1'b1, 8'h77, 32'h7777_0001);
        step(1'b0, 8'h00, 32'h0);
        repeat (3) step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((err_timeout !== 1'b0) || (mem_req !== 1'b1)) begin
            n_err++;
            $display("FAIL timeout_early: got err %b req %b want 0 1", err_timeout, mem_req);
        end
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((err_timeout !== 1'b1) || (mem_req !== 1'b1)) begin
            n_err++;
            $display("FAIL timeout_hit: got err %b req %b want 1 1", err_timeout, mem_req);
        end
        repeat (6) step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_hold: got %b want 1", mem_req);
        end
        ack_en = 1'b1;
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if (del !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_del: got %b want 1", del);
        end
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((head_idx !== 6'd6) || (err_timeout !== 1'b1)) begin
            n_err++;
            $display("FAIL timeout_done: got idx %0d err %b want 6 1", head_idx, err_timeout);
        end
    endtask

    task automatic test_wrap_full();
        logic [5:0] start_head;
        int         start_dels;
        start_head = m_head;
        ack_en     = 1'b0;
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL full_ovf_pre: got %b want 0", err_ovf);
        end
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 8'($urandom), $urandom);
        end
        n_cmp++;
        if ((pend_cnt !== 7'd64) || (stall !== 1'b1)) begin
            n_err++;
            $display("FAIL full_stall: got pend %0d stall %b want 64 1", pend_cnt, stall);
        end
        step(1'b1, 8'hEE, 32'hEEEE_EEEE);
        n_cmp++;
        if ((err_ovf !== 1'b1) || (pend_cnt !== 7'd64)) begin
            n_err++;
            $display("FAIL full_ovf: got err %b pend %0d want 1 64", err_ovf, pend_cnt);
        end
        ack_en     = 1'b1;
        start_dels = del_seen;
        for (int k = 0; k < 64 * 3 + 20 && m_pend != 0; k++) begin
            step(1'b0, 8'h00, 32'h0);
        end
        n_cmp++;
        if (m_pend != 0) begin
            n_err++;
            $display("FAIL full_drain_budget: got pend %0d want 0 within budget", pend_cnt);
        end
        n_cmp++;
        if ((del_seen - start_dels != 64) || (head_idx !== start_head) || (stall !== 1'b0)) begin
            n_err++;
            $display("FAIL full_drain: got dels %0d idx %0d stall %b want 64 %0d 0",
                     del_seen - start_dels, head_idx, stall, start_head);
        end
    endtask

    task automatic test_reset_mid_req();
        ack_en = 1'b0;
        step(1'b1, 8'h3C, 32'h3C3C_3C3C);
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: got %b want 1", mem_req);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, del, stall, err_nodata, err_timeout, err_ovf} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid_flags: got %b want 000000",
                     {mem_req, del, stall, err_nodata, err_timeout, err_ovf});
        end
        n_cmp++;
        if ((pend_cnt !== 7'd0) || (head_idx !== 6'd0) || (mem_addr !== 8'd0)) begin
            n_err++;
            $display("FAIL rst_mid_regs: got pend %0d idx %0d addr %h want 0 0 00", pend_cnt, head_idx, mem_addr);
        end
        #1;
        rstn   = 1'b1;
        m_pend = 0;
        m_head = 6'd0;
        m_tail = 6'd0;
        sb_q.delete();
        ack_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 32'h0);
            n_cmp++;
            if (mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_replay: got %b want 0", mem_req);
            end
        end
        step(1'b1, 8'hA5, 32'h0123_4567);
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((mem_req !== 1'b1) || (mem_addr !== 8'hA5) || (mem_wdata !== 32'h0123_4567)) begin
            n_err++;
            $display("FAIL rst_mid_new: got %b %h/%h want 1 a5/01234567", mem_req, mem_addr, mem_wdata);
        end
        step(1'b0, 8'h00, 32'h0);
        step(1'b0, 8'h00, 32'h0);
        n_cmp++;
        if ((head_idx !== 6'd1) || (pend_cnt !== 7'd0)) begin
            n_err++;
            $display("FAIL rst_mid_done: got idx %0d pend %0d want 1 0", head_idx, pend_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            sq_addr[i] = 8'd0;
            sq_data[i] = 32'd0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_nodata();
        test_timeout();
        test_wrap_full();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
